// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction fetch unit with a prefetch queue.
// Issues in-order word fetches over a valid/ready request channel. It buffers up to DEPTH
// {pc, instruction} pairs for decode. A redirect flushes the queue and marks every in-flight
// request as stale, so that its response is discarded on return.
// Optional macro IFU_MISALIGN_CHK_EN: a misaligned redirect raises a sticky error and halts fetch.
module ifu_prefetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_redirect_vld,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req_vld,
  input  logic        i_imem_req_rdy,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_rsp_vld,
  input  logic [31:0] i_imem_rsp_data,
  output logic        o_inst_vld,
  input  logic        i_inst_rdy,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_misalign_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);

  logic          started_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;

  // Address FIFO: fetch addresses of live (non-stale) requests, in issue order.
  logic [31:0]   af_mem [DEPTH];
  logic [AW-1:0] af_wr_q, af_wr_d, af_rd_q, af_rd_d;

  // Instruction queue presented to decode.
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [AW-1:0] q_wr_q, q_wr_d, q_rd_q, q_rd_d;
  logic [CW-1:0] count_q, count_d;

  logic [OW-1:0] outst_q, outst_d, drop_q, drop_d;

  logic [31:0]   occupancy;
  logic [31:0]   redirect_target;
  logic          halt;
  logic          fire, rsp_keep, rsp_drop, pop;

`ifdef IFU_MISALIGN_CHK_EN
  logic misalign_q;

  // Sticky trap: any misaligned redirect halts fetching until reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_q | (i_redirect_vld & (i_redirect_pc[1:0] != 2'b00));
    end
  end

  assign halt            = misalign_q;
  assign redirect_target = i_redirect_pc;
  assign o_misalign_err  = misalign_q;
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^i_redirect_pc[1:0];

  assign halt            = 1'b0;
  assign redirect_target = {i_redirect_pc[31:2], 2'b00};
  assign o_misalign_err  = 1'b0;
`endif

  // Request issue and handshake decode. Issue depends on state only, so the request
  // stays stable until it fires or a redirect moves the fetch PC.
  always_comb begin
    // Stale requests still count in outst but will never occupy a queue slot.
    occupancy       = 32'(count_q) + 32'(outst_q) - 32'(drop_q);
    o_imem_req_vld  = started_q & ~halt & (32'(outst_q) < MAX_OUTST) & (occupancy < DEPTH);
    o_imem_req_addr = fetch_pc_q;
    fire            = o_imem_req_vld & i_imem_req_rdy;
    rsp_drop        = i_imem_rsp_vld & (drop_q != '0);
    rsp_keep        = i_imem_rsp_vld & (drop_q == '0);
    o_inst_vld      = (count_q != '0);
    pop             = o_inst_vld & i_inst_rdy;
    o_inst          = o_inst_vld ? q_data[q_rd_q] : '0;
    o_pc            = o_inst_vld ? q_pc[q_rd_q] : '0;
  end

  // Next-state for fetch PC, pointers and occupancy counters.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    af_wr_d    = af_wr_q;
    af_rd_d    = af_rd_q;
    q_wr_d     = q_wr_q;
    q_rd_d     = q_rd_q;
    count_d    = count_q + CW'(rsp_keep) - CW'(pop);
    outst_d    = outst_q + OW'(fire) - OW'(i_imem_rsp_vld);
    drop_d     = drop_q - OW'(rsp_drop);

    if (fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      af_wr_d    = af_wr_q + AW'(1);
    end
    if (rsp_keep) begin
      af_rd_d = af_rd_q + AW'(1);
      q_wr_d  = q_wr_q + AW'(1);
    end
    if (pop) begin
      q_rd_d = q_rd_q + AW'(1);
    end

    // Everything still outstanding after this cycle, including a same-cycle fire, is stale.
    if (i_redirect_vld) begin
      fetch_pc_d = redirect_target;
      af_wr_d    = '0;
      af_rd_d    = '0;
      q_wr_d     = '0;
      q_rd_d     = '0;
      count_d    = '0;
      drop_d     = outst_d;
    end
  end

  // Control state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      started_q  <= 1'b0;
      fetch_pc_q <= RESET_PC;
      af_wr_q    <= '0;
      af_rd_q    <= '0;
      q_wr_q     <= '0;
      q_rd_q     <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      started_q  <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      af_wr_q    <= af_wr_d;
      af_rd_q    <= af_rd_d;
      q_wr_q     <= q_wr_d;
      q_rd_q     <= q_rd_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  // Storage arrays need no reset; validity is tracked by the pointers and counters.
  always_ff @(posedge i_clk) begin
    if (fire) begin
      af_mem[af_wr_q] <= fetch_pc_q;
    end
    if (rsp_keep) begin
      q_pc[q_wr_q]   <= af_mem[af_rd_q];
      q_data[q_wr_q] <= i_imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: table-driven fetch streams plus hand-written redirect, stall and reset
// sequences. A bench memory model returns ~addr as data with a configurable latency.
// Expected PCs are queued when a stream starts and compared when decode consumes them.
module tb_ifu_prefetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_vld;
  logic [31:0] redirect_pc;
  logic        req_vld;
  logic        req_rdy;
  logic [31:0] req_addr;
  logic        rsp_vld;
  logic [31:0] rsp_data;
  logic        inst_vld;
  logic        inst_rdy;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        misalign_err;

  always #5 clk = ~clk;

  ifu_prefetch #(
    .RESET_PC (32'h0000_0100),
    .DEPTH    (4),
    .MAX_OUTST(2)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_redirect_vld (redirect_vld),
    .i_redirect_pc  (redirect_pc),
    .o_imem_req_vld (req_vld),
    .i_imem_req_rdy (req_rdy),
    .o_imem_req_addr(req_addr),
    .i_imem_rsp_vld (rsp_vld),
    .i_imem_rsp_data(rsp_data),
    .o_inst_vld     (inst_vld),
    .i_inst_rdy     (inst_rdy),
    .o_inst         (inst),
    .o_pc           (pc),
    .o_misalign_err (misalign_err)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    int          lat;
    logic [31:0] start_pc;
    int          n;
    bit          rnd;
    logic [31:0] last_pc;
  } vec_t;

  mreq_t       mq[$];
  logic [31:0] exp_q[$];
  vec_t        vecs[5];

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          fires = 0;
  int          consumed = 0;
  int          lat = 1;
  int          first_vld = -1;
  bit          mem_rdy = 1'b1;
  bit          cons_rdy = 1'b0;
  bit          rnd = 1'b0;
  bit          redir_req = 1'b0;
  logic [31:0] redir_pc = '0;
  logic [31:0] last_pc = '0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_stream(input logic [31:0] start, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(start + 32'(4 * k));
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic tick();
    mreq_t       m;
    logic [31:0] e;
    rsp_vld  = 1'b0;
    rsp_data = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      m        = mq.pop_front();
      rsp_vld  = 1'b1;
      rsp_data = ~m.addr;
    end
    req_rdy = mem_rdy;
    if (req_vld && mem_rdy) begin
      m.addr = req_addr;
      m.due  = cyc + lat;
      mq.push_back(m);
      fires++;
    end
    checks++;
    if (mq.size() > 2) begin
      errors++;
      $display("FAIL max_outst: got %0d outstanding, required <= 2", mq.size());
    end
    if (first_vld < 0 && inst_vld) first_vld = cyc;
    inst_rdy = cons_rdy;
    if (inst_vld && cons_rdy) begin
      consumed++;
      last_pc = pc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_inst: got pc %h, required no instruction", pc);
      end else begin
        e = exp_q.pop_front();
        check32("inst_pc", pc, e);
        check32("inst_data", inst, ~e);
      end
    end
    redirect_vld = redir_req;
    redirect_pc  = redir_pc;
    if (redir_req) begin
      exp_q.delete();
      redir_req = 1'b0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_until(input int target, input int budget);
    int n = 0;
    while (consumed < target && n < budget) begin
      if (rnd) begin
        cons_rdy = 1'($urandom_range(0, 1));
        mem_rdy  = 1'($urandom_range(0, 1));
      end else begin
        cons_rdy = 1'b1;
        mem_rdy  = 1'b1;
      end
      tick();
      n++;
    end
    checks++;
    if (consumed < target) begin
      errors++;
      $display("FAIL run_timeout: got %0d consumed, required %0d", consumed, target);
    end
    cons_rdy = 1'b0;
    mem_rdy  = 1'b1;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redir_req = 1'b1;
    redir_pc  = target;
    tick();
  endtask

  initial begin
    int n;
    int c0;
    int f0;
    vecs[0] = '{lat: 1, start_pc: 32'h0000_1000, n: 8, rnd: 1'b0, last_pc: 32'h0000_101C};
    vecs[1] = '{lat: 2, start_pc: 32'h0000_2000, n: 6, rnd: 1'b0, last_pc: 32'h0000_2014};
    vecs[2] = '{lat: 3, start_pc: 32'h0000_3000, n: 6, rnd: 1'b1, last_pc: 32'h0000_3014};
    vecs[3] = '{lat: 1, start_pc: 32'hFFFF_FFF8, n: 4, rnd: 1'b0, last_pc: 32'h0000_0004};
    vecs[4] = '{lat: 2, start_pc: 32'h8000_0000, n: 5, rnd: 1'b1, last_pc: 32'h8000_0010};

    rst_n        = 1'b0;
    redirect_vld = 1'b0;
    redirect_pc  = '0;
    req_rdy      = 1'b1;
    rsp_vld      = 1'b0;
    rsp_data     = '0;
    inst_rdy     = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset values.
    check32("rst_req_vld", 32'(req_vld), 32'd0);
    check32("rst_req_addr", req_addr, 32'h0000_0100);
    check32("rst_inst_vld", 32'(inst_vld), 32'd0);
    check32("rst_inst", inst, 32'd0);
    check32("rst_pc", pc, 32'd0);
    check32("rst_misalign", 32'(misalign_err), 32'd0);

    // Startup: first instruction at cycle 3, then one per cycle.
    rst_n = 1'b1;
    lat   = 1;
    push_stream(32'h0000_0100, 12);
    run_until(12, 40);
    check32("first_vld_cycle", 32'(first_vld), 32'd3);
    check32("sustained_end_cycle", 32'(cyc), 32'd15);

    // Decode stalled: queue fills to DEPTH and requests stop.
    for (int i = 0; i < 20; i++) tick();
    check32("stall_req_vld", 32'(req_vld), 32'd0);
    check32("stall_inst_vld", 32'(inst_vld), 32'd1);
    check32("stall_buffered", 32'(fires - consumed), 32'd4);
    check32("stall_mem_idle", 32'(mq.size()), 32'd0);
    push_stream(32'h0000_0130, 8);
    run_until(consumed + 8, 60);

    // 3-cycle memory: redirect while two requests are in flight.
    lat = 3;
    redirect_to(32'h0000_0400);
    f0 = fires;
    n  = 0;
    while (!((fires - f0) >= 2 && mq.size() == 2) && n < 30) begin
      tick();
      n++;
    end
    check32("two_in_flight", 32'(mq.size()), 32'd2);
    redirect_to(32'h0000_0200);
    check32("redir_inst_vld", 32'(inst_vld), 32'd0);
    check32("redir_req_addr", req_addr, 32'h0000_0200);
    push_stream(32'h0000_0200, 8);
    run_until(consumed + 8, 80);

    // Redirect in the same cycle as a request fire and a decode handshake.
    lat = 1;
    redirect_to(32'h0000_0600);
    push_stream(32'h0000_0600, 8);
    cons_rdy = 1'b1;
    n = 0;
    while (!(inst_vld && req_vld) && n < 30) begin
      tick();
      n++;
    end
    c0 = consumed;
    f0 = fires;
    redirect_to(32'h0000_0200);
    check32("same_cycle_handshake", 32'(consumed - c0), 32'd1);
    check32("same_cycle_fire", 32'(fires - f0), 32'd1);
    check32("same_cycle_req_addr", req_addr, 32'h0000_0200);
    cons_rdy = 1'b0;
    push_stream(32'h0000_0200, 4);
    run_until(consumed + 4, 40);

    // Table-driven streams, including a fetch PC wrap through zero.
    for (int i = 0; i < 5; i++) begin
      lat = vecs[i].lat;
      redirect_to(vecs[i].start_pc);
      push_stream(vecs[i].start_pc, vecs[i].n);
      rnd = vecs[i].rnd;
      run_until(consumed + vecs[i].n, 200);
      rnd = 1'b0;
      check32("vec_last_pc", last_pc, vecs[i].last_pc);
    end

    // Misaligned redirect.
    lat = 1;
    redirect_to(32'h0000_0302);
`ifdef IFU_MISALIGN_CHK_EN
    check32("misalign_set", 32'(misalign_err), 32'd1);
    f0 = fires;
    for (int i = 0; i < 6; i++) tick();
    check32("misalign_no_fire", 32'(fires - f0), 32'd0);
    check32("misalign_req_vld", 32'(req_vld), 32'd0);
    check32("misalign_sticky", 32'(misalign_err), 32'd1);
`else
    check32("misalign_clear", 32'(misalign_err), 32'd0);
    check32("misalign_req_addr", req_addr, 32'h0000_0300);
    push_stream(32'h0000_0300, 4);
    run_until(consumed + 4, 40);
`endif

    // Asynchronous reset in the middle of a cycle clears state at once.
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst_n = 1'b0;
    mq.delete();
    #1;
    check32("async_rst_inst_vld", 32'(inst_vld), 32'd0);
    check32("async_rst_req_vld", 32'(req_vld), 32'd0);
    check32("async_rst_req_addr", req_addr, 32'h0000_0100);
    check32("async_rst_misalign", 32'(misalign_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
